// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory-access path: transaction FSM encoding
// and the default address width / wait limit used by mem_access_unit.
package cpu_pkg;

  localparam int DATA_W         = 32;
  localparam int ADDR_W_DEF     = 9;
  localparam int WAIT_LIMIT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mdr_mar_regs.sv
// Memory address register and memory data register: two plain load-enabled
// registers with asynchronous active-low clear.
module mdr_mar_regs
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              mar_ld,
  input  logic [ADDR_W-1:0] mar_d,
  input  logic              mdr_ld,
  input  logic [DATA_W-1:0] mdr_d,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] mdr_q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mar_q <= '0;
    end else if (mar_ld) begin
      mar_q <= mar_d;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mdr_q <= '0;
    end else if (mdr_ld) begin
      mdr_q <= mdr_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR datapath plus a read/write transaction FSM with
// a bounded wait for the RAM handshake and a sticky timeout error flag.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  mem_state_t        state;
  mem_state_t        state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              in_idle;
  logic              in_req;
  logic              rd_start;
  logic              start;
  logic              timeout;
  logic              mar_ld;
  logic              mdr_ld;
  logic [DATA_W-1:0] mdr_d;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;

  assign in_idle  = (state == IDLE);
  assign in_req   = (state == RD_REQ) || (state == WR_REQ);
  assign rd_start = in_idle && MDRin && Read;
  assign start    = rd_start || (in_idle && Write);
  // The final permitted wait cycle: the counter would reach WAIT_LIMIT at this edge.
  assign timeout  = in_req && !mem_ready && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

  assign mar_ld = in_idle && MARin;
  assign mdr_ld = (in_idle && MDRin && !Read) || ((state == RD_REQ) && mem_ready);
  assign mdr_d  = in_idle ? BusMuxOut : mem_rdata;

  mdr_mar_regs #(
    .ADDR_W(ADDR_W)
  ) u_regs (
    .clk    (clk),
    .clr_n  (clr_n),
    .mar_ld (mar_ld),
    .mar_d  (BusMuxOut[ADDR_W-1:0]),
    .mdr_ld (mdr_ld),
    .mdr_d  (mdr_d),
    .mar_q  (mar_q),
    .mdr_q  (mdr_q)
  );

  assign mem_addr    = mar_q;
  assign mem_wdata   = mdr_q;
  assign BusMuxInMDR = mdr_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rd_start) begin
          state_next = RD_REQ;
        end else if (Write) begin
          state_next = WR_REQ;
        end
      end
      RD_REQ, WR_REQ: begin
        if (mem_ready || timeout) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      RD_REQ: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
      end
      WR_REQ: begin
        mem_wr = 1'b1;
        busy   = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= '0;
    end else if (in_req && !mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // err survives the return to IDLE so the control unit can inspect it later.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err <= 1'b0;
    end else if (start) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end

endmodule
